// File: rtl/axis_frame_serializer_if.sv
// Handshake bundle for the frame serializer: the parallel vector input and the AXI4-Stream output.
// The serializer uses the master view; the producer/consumer side uses the slave view.
interface axis_frame_serializer_if #(
   parameter int AXIS_WIDTH  = 32,
   parameter int NO_CHANNELS = 4
);
   logic                              in_valid;
   logic                              in_ready;
   logic [AXIS_WIDTH*NO_CHANNELS-1:0] in_data;
   logic                              M_AXIS_TREADY;
   logic                              M_AXIS_TVALID;
   logic                              M_AXIS_TLAST;
   logic [AXIS_WIDTH-1:0]             M_AXIS_TDATA;
   logic [AXIS_WIDTH/8-1:0]           M_AXIS_TSTRB;

   modport master (
      input  in_valid, in_data, M_AXIS_TREADY,
      output in_ready, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TSTRB
   );

   modport slave (
      output in_valid, in_data, M_AXIS_TREADY,
      input  in_ready, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TSTRB
   );
endinterface

// File: rtl/axis_frame_serializer.sv
// Serializes enabled channels of each parallel vector onto AXI4-Stream, with TLAST every
// frame_len vectors. ACTIVE drains while PENDING holds the next vector.
module axis_frame_serializer #(
   parameter int AXIS_WIDTH      = 32,
   parameter int NO_CHANNELS     = 4,
   parameter int FRAME_LEN_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NO_CHANNELS-1:0]     chan_enable,
   input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
   axis_frame_serializer_if.master    bus
);
   localparam int VW = AXIS_WIDTH * NO_CHANNELS;

   logic [VW-1:0]              act_data_reg;
   logic [NO_CHANNELS-1:0]     act_rem_reg;
   logic                       act_valid_reg;
   logic [VW-1:0]              pend_data_reg;
   logic                       pend_valid_reg;
   logic [NO_CHANNELS-1:0]     frame_mask_reg;
   logic [FRAME_LEN_WIDTH-1:0] frame_target_reg;
   logic [FRAME_LEN_WIDTH-1:0] vec_cnt_reg;
   logic                       frame_start_reg;

   logic                       rem_empty;
   logic                       last_word;
   logic                       frame_end;
   logic                       tvalid;
   logic                       beat;
   logic                       release_act;
   logic                       act_free;
   logic                       accept;
   logic                       load_act;
   logic                       start_now;
   logic [NO_CHANNELS-1:0]     load_mask;
   logic [AXIS_WIDTH-1:0]      sel_data;

   assign rem_empty   = (act_rem_reg == '0);
   assign last_word   = !rem_empty && ((act_rem_reg & (act_rem_reg - NO_CHANNELS'(1))) == '0);
   assign frame_end   = (frame_target_reg != '0) &&
                        (vec_cnt_reg == frame_target_reg - FRAME_LEN_WIDTH'(1));
   assign tvalid      = act_valid_reg && !rem_empty;
   assign beat        = tvalid && bus.M_AXIS_TREADY;
   // An all-zero mask leaves ACTIVE with nothing to send, so it retires without a beat.
   assign release_act = act_valid_reg && (rem_empty || (beat && last_word));
   assign act_free    = !act_valid_reg || release_act;
   assign accept      = bus.in_valid && !pend_valid_reg;
   assign load_act    = act_free && (pend_valid_reg || accept);
   assign start_now   = frame_start_reg || (release_act && frame_end);
   assign load_mask   = start_now ? chan_enable : frame_mask_reg;

   // Lowest set bit of the remaining mask selects the channel on the bus.
   always_comb begin
      sel_data = '0;
      for (int i = NO_CHANNELS - 1; i >= 0; i--) begin
         if (act_rem_reg[i]) begin
            sel_data = act_data_reg[i*AXIS_WIDTH +: AXIS_WIDTH];
         end
      end
   end

   assign bus.in_ready      = !pend_valid_reg;
   assign bus.M_AXIS_TVALID = tvalid;
   assign bus.M_AXIS_TLAST  = tvalid && last_word && frame_end;
   assign bus.M_AXIS_TDATA  = sel_data;
   assign bus.M_AXIS_TSTRB  = '1;

   always_ff @(posedge clk) begin
      if (reset) begin
         act_data_reg     <= '0;
         act_rem_reg      <= '0;
         act_valid_reg    <= 1'b0;
         pend_data_reg    <= '0;
         pend_valid_reg   <= 1'b0;
         frame_mask_reg   <= '0;
         frame_target_reg <= '0;
         vec_cnt_reg      <= '0;
         frame_start_reg  <= 1'b1;
      end else begin
         if (release_act) begin
            vec_cnt_reg <= frame_end ? '0 : vec_cnt_reg + FRAME_LEN_WIDTH'(1);
         end
         if (beat) begin
            act_rem_reg <= act_rem_reg & (act_rem_reg - NO_CHANNELS'(1));
         end

         // PENDING has priority over the input port when ACTIVE frees up.
         if (act_free) begin
            if (pend_valid_reg) begin
               act_data_reg   <= pend_data_reg;
               act_valid_reg  <= 1'b1;
               pend_valid_reg <= 1'b0;
            end else if (accept) begin
               act_data_reg  <= bus.in_data;
               act_valid_reg <= 1'b1;
            end else begin
               act_valid_reg <= 1'b0;
            end
         end else if (accept) begin
            pend_data_reg  <= bus.in_data;
            pend_valid_reg <= 1'b1;
         end

         if (load_act) begin
            act_rem_reg <= load_mask;
            if (start_now) begin
               frame_mask_reg   <= chan_enable;
               frame_target_reg <= frame_len;
               vec_cnt_reg      <= '0;
               frame_start_reg  <= 1'b0;
            end
         end else if (release_act && frame_end) begin
            frame_start_reg <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axis_frame_serializer.sv
// Self-checking bench: table of frame scenarios plus hand-written corner sequences,
// every output beat checked against a scoreboard filled when vectors are accepted.
module tb_axis_frame_serializer;
   localparam int W   = 32;
   localparam int N   = 4;
   localparam int FLW = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   chan_enable;
   logic [FLW-1:0] frame_len;

   axis_frame_serializer_if #(.AXIS_WIDTH(W), .NO_CHANNELS(N)) bus();

   axis_frame_serializer #(.AXIS_WIDTH(W), .NO_CHANNELS(N), .FRAME_LEN_WIDTH(FLW)) dut (
      .clk         (clk),
      .reset       (reset),
      .chan_enable (chan_enable),
      .frame_len   (frame_len),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   typedef struct {
      logic [N-1:0]   mask;
      logic [FLW-1:0] flen;
      int             nvec;
      int             base;
      int             tmode;
      int             exp_beats;
      int             exp_lasts;
   } row_t;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    beats = 0;
   int    lasts = 0;
   int    tready_mode = 1;
   time   first_t, last_t, acc0_t;
   bit    got_acc0;

   bit             m_start;
   logic [N-1:0]   m_mask;
   logic [FLW-1:0] m_target;
   logic [FLW-1:0] m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W*N-1:0] mkvec(input int base, input int k);
      logic [W*N-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + 16*k + i);
      return v;
   endfunction

   // Reference behaviour: frame state is taken at the frame's first vector.
   task automatic model_push(input logic [W*N-1:0] d);
      int    hi;
      beat_t e;
      if (m_start) begin
         m_mask   = chan_enable;
         m_target = frame_len;
         m_cnt    = '0;
         m_start  = 1'b0;
      end
      hi = -1;
      for (int i = 0; i < N; i++) if (m_mask[i]) hi = i;
      for (int i = 0; i < N; i++) begin
         if (m_mask[i]) begin
            e.data = d[i*W +: W];
            e.last = (i == hi) && (m_target != '0) && (m_cnt == m_target - 16'd1);
            exp_q.push_back(e);
         end
      end
      if ((m_target != '0) && (m_cnt == m_target - 16'd1)) begin
         m_cnt   = '0;
         m_start = 1'b1;
      end else begin
         m_cnt = m_cnt + 16'd1;
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_start  = 1'b1;
      beats    = 0;
      lasts    = 0;
      got_acc0 = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_model();
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic send(input logic [W*N-1:0] d);
      int n;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (!got_acc0) begin
         acc0_t   = $time;
         got_acc0 = 1'b1;
      end
      model_push(d);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.M_AXIS_TVALID || !bus.in_ready) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      if (n >= 5000) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d words outstanding, expected 0", exp_q.size());
      end
   endtask

   // TREADY driver: 0 = held low, 1 = held high, 2 = random.
   initial begin
      bus.M_AXIS_TREADY = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (tready_mode)
            0:       bus.M_AXIS_TREADY = 1'b0;
            1:       bus.M_AXIS_TREADY = 1'b1;
            default: bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: scoreboard compare on each beat, plus hold-while-stalled check.
   initial begin
      bit           stall = 1'b0;
      logic [W-1:0] stall_data = '0;
      logic         stall_last = 1'b0;
      beat_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               n_vec++;
               if (!(bus.M_AXIS_TVALID && bus.M_AXIS_TDATA == stall_data &&
                     bus.M_AXIS_TLAST == stall_last)) begin
                  n_err++;
                  $display("FAIL stall_hold: got valid=%0b data=%0h last=%0b, expected valid=1 data=%0h last=%0b",
                           bus.M_AXIS_TVALID, bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, stall_data, stall_last);
               end
            end
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
               if (beats == 0) first_t = $time;
               last_t = $time;
               beats++;
               if (bus.M_AXIS_TLAST) lasts++;
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_beat: got data=%0h last=%0b, expected no beat",
                           bus.M_AXIS_TDATA, bus.M_AXIS_TLAST);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.M_AXIS_TDATA !== e.data || bus.M_AXIS_TLAST !== e.last) begin
                     n_err++;
                     $display("FAIL beat: got data=%0h last=%0b, expected data=%0h last=%0b",
                              bus.M_AXIS_TDATA, bus.M_AXIS_TLAST, e.data, e.last);
                  end
               end
            end
            stall      = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
            stall_data = bus.M_AXIS_TDATA;
            stall_last = bus.M_AXIS_TLAST;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t rows[7];
      rows[0] = '{4'b1111, 16'd2, 2, 'h10,  1, 8,  1};
      rows[1] = '{4'b1010, 16'd1, 1, 'hA0,  1, 2,  1};
      rows[2] = '{4'b0100, 16'd2, 4, 'h100, 2, 4,  2};
      rows[3] = '{4'b1101, 16'd3, 6, 'h200, 2, 18, 2};
      rows[4] = '{4'b0001, 16'd0, 5, 'h300, 1, 5,  0};
      rows[5] = '{4'b0000, 16'd3, 3, 'h400, 1, 0,  0};
      rows[6] = '{4'b1000, 16'd1, 3, 'h500, 2, 3,  3};

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      chan_enable  = 4'b1111;
      frame_len    = '0;
      clear_model();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tvalid",   64'(bus.M_AXIS_TVALID), 64'd0);
      chk("reset_tlast",    64'(bus.M_AXIS_TLAST),  64'd0);
      chk("reset_tdata",    64'(bus.M_AXIS_TDATA),  64'd0);
      chk("reset_in_ready", 64'(bus.in_ready),      64'd1);
      chk("tstrb",          64'(bus.M_AXIS_TSTRB),  64'hF);
      reset = 1'b0;

      for (int r = 0; r < 7; r++) begin
         do_reset();
         chan_enable = rows[r].mask;
         frame_len   = rows[r].flen;
         tready_mode = rows[r].tmode;
         for (int k = 0; k < rows[r].nvec; k++) send(mkvec(rows[r].base, k));
         drain();
         chk($sformatf("row%0d_beats", r), 64'(beats), 64'(rows[r].exp_beats));
         chk($sformatf("row%0d_lasts", r), 64'(lasts), 64'(rows[r].exp_lasts));
         if (r == 0) begin
            chk("first_word_latency", 64'(first_t - acc0_t), 64'd5);
            chk("back_to_back_span",  64'(last_t - first_t), 64'd70);
         end
      end

      // Mask change while a vector drains only affects the next frame.
      do_reset();
      chan_enable = 4'b1010;
      frame_len   = 16'd1;
      tready_mode = 1;
      send(mkvec('hA0, 0));
      chan_enable = 4'b0001;
      send(mkvec('hB0, 0));
      drain();
      chk("maskchg_beats", 64'(beats), 64'd3);
      chk("maskchg_lasts", 64'(lasts), 64'd2);

      // Stall with both buffers full.
      do_reset();
      chan_enable = 4'b1111;
      frame_len   = 16'd0;
      tready_mode = 0;
      send(mkvec('hC0, 0));
      send(mkvec('hD0, 0));
      bus.in_data  = mkvec('hE0, 0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("full_in_ready", 64'(bus.in_ready),      64'd0);
         chk("full_tvalid",   64'(bus.M_AXIS_TVALID), 64'd1);
         chk("full_tdata",    64'(bus.M_AXIS_TDATA),  64'hC0);
      end
      tready_mode = 1;
      send(mkvec('hE0, 0));
      drain();
      chk("stall_beats", 64'(beats), 64'd12);

      // Silent all-zero frame, then a new frame with channel 2 only.
      do_reset();
      chan_enable = 4'b0000;
      frame_len   = 16'd3;
      tready_mode = 1;
      for (int k = 0; k < 3; k++) send(mkvec('h600, k));
      chan_enable = 4'b0100;
      for (int k = 0; k < 3; k++) send(mkvec('h700, k));
      drain();
      chk("zeromask_beats", 64'(beats), 64'd3);
      chk("zeromask_lasts", 64'(lasts), 64'd1);

      // Reset while PENDING is full and TVALID is high.
      do_reset();
      chan_enable = 4'b1111;
      frame_len   = 16'd2;
      tready_mode = 0;
      send(mkvec('h800, 0));
      send(mkvec('h800, 1));
      chk("prereset_in_ready", 64'(bus.in_ready),      64'd0);
      chk("prereset_tvalid",   64'(bus.M_AXIS_TVALID), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_tvalid",   64'(bus.M_AXIS_TVALID), 64'd0);
      chk("midreset_in_ready", 64'(bus.in_ready),      64'd1);
      reset = 1'b0;
      clear_model();
      tready_mode = 1;
      send(mkvec('h900, 0));
      send(mkvec('h900, 1));
      drain();
      chk("postreset_beats", 64'(beats), 64'd8);
      chk("postreset_lasts", 64'(lasts), 64'd1);

      // Unframed long run wraps the vector counter.
      do_reset();
      chan_enable = 4'b0001;
      frame_len   = 16'd0;
      tready_mode = 1;
      for (int k = 0; k < 66000; k++) send(mkvec(0, k));
      drain();
      chk("wrap_beats", 64'(beats), 64'd66000);
      chk("wrap_lasts", 64'(lasts), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
